// File: rtl/path_sequencer.sv
// Path sequencer: holds a packed node path and steps prev/curr/next pointers on node_adv.
// Optional sentinel termination on END_NODE is enabled with `define PATH_SENTINEL_EN.
module path_sequencer #(
   parameter int NODE_W    = 5,
   parameter int MAX_NODES = 14,
   parameter int IDX_W     = $clog2(MAX_NODES + 1),
   parameter int END_NODE  = 6
) (
   input  logic                          node_clk,
   input  logic                          reset,
   input  logic [NODE_W*MAX_NODES-1:0]   path_in,
   input  logic [IDX_W-1:0]              path_len,
   input  logic                          path_valid,
   output logic                          path_ready,
   input  logic                          node_adv,
   input  logic                          abort,
   output logic [NODE_W-1:0]             prev_node,
   output logic [NODE_W-1:0]             curr_node,
   output logic [NODE_W-1:0]             next_node,
   output logic [IDX_W-1:0]              node_idx,
   output logic                          busy,
   output logic                          path_done,
   output logic                          new_path,
   output logic                          len_err,
   output logic [1:0]                    fsm_state
);

   // Load handshake: a load happens on any edge where path_valid && path_ready;
   // path_ready is a pure function of state, so it never depends on path_valid.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                        state_q, state_d;
   logic [NODE_W*MAX_NODES-1:0]   path_q;
   logic [IDX_W-1:0]              len_q;
   logic [NODE_W-1:0]             prev_q, curr_q, next_q;
   logic [IDX_W-1:0]              idx_q;
   logic                          done_q;
   logic                          len_err_q;

   logic                          len_ok;
   logic                          load_req;
   logic                          load_go;
   logic                          load_bad;
   logic                          load_end;
   logic                          adv_go;
   logic                          reach_end;
   logic [IDX_W-1:0]              idx_inc;
   logic [IDX_W-1:0]              last_idx;
   logic [IDX_W:0]                idx2;
   logic [NODE_W-1:0]             sel_node;

   always_comb begin
      len_ok   = (path_len >= IDX_W'(2)) && (path_len <= IDX_W'(MAX_NODES));
      load_req = path_valid && path_ready;
      load_go  = load_req && len_ok;
      load_bad = load_req && !len_ok;
      adv_go   = (state_q == RUN) && node_adv && !abort;
      idx_inc  = idx_q + IDX_W'(1);
      last_idx = len_q - IDX_W'(1);
      idx2     = {1'b0, idx_q} + (IDX_W + 1)'(2);
`ifdef PATH_SENTINEL_EN
      load_end  = (path_in[NODE_W-1:0] == NODE_W'(END_NODE));
      reach_end = adv_go && ((idx_inc == last_idx) || (next_q == NODE_W'(END_NODE)));
`else
      load_end  = 1'b0;
      reach_end = adv_go && (idx_inc == last_idx);
`endif
   end

   // Look-ahead node mux; only in-range slots exist, so no out-of-range read is possible.
   always_comb begin
      sel_node = '0;
      for (int k = 0; k < MAX_NODES; k++) begin
         if (idx2 == (IDX_W + 1)'(k)) sel_node = path_q[k*NODE_W +: NODE_W];
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE, DONE: begin
            if (load_go) state_d = load_end ? DONE : RUN;
         end
         RUN: begin
            if (abort)          state_d = IDLE;
            else if (reach_end) state_d = DONE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge node_clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_ff @(posedge node_clk) begin
      if (reset) begin
         path_q    <= '0;
         len_q     <= '0;
         prev_q    <= '0;
         curr_q    <= '0;
         next_q    <= '0;
         idx_q     <= '0;
         done_q    <= 1'b0;
         len_err_q <= 1'b0;
      end else begin
         done_q    <= 1'b0;
         len_err_q <= load_bad;
         if (load_go) begin
            path_q <= path_in;
            len_q  <= path_len;
            prev_q <= path_in[0 +: NODE_W];
            curr_q <= path_in[0 +: NODE_W];
            next_q <= path_in[NODE_W +: NODE_W];
            idx_q  <= '0;
            done_q <= load_end;
         end else if (adv_go) begin
            idx_q  <= idx_inc;
            prev_q <= curr_q;
            curr_q <= next_q;
            // Past the end of the path the look-ahead holds the last node.
            if (idx2 < {1'b0, len_q}) next_q <= sel_node;
            done_q <= reach_end;
         end
      end
   end

   always_comb begin
      path_ready = (state_q == IDLE) || (state_q == DONE);
      busy       = (state_q == RUN);
      new_path   = (state_q == DONE);
      path_done  = done_q;
      len_err    = len_err_q;
      prev_node  = prev_q;
      curr_node  = curr_q;
      next_node  = next_q;
      node_idx   = idx_q;
      fsm_state  = state_q;
   end

endmodule

// File: tb/tb_path_sequencer.sv
// Scoreboard bench for path_sequencer: expected output snapshots are queued per driven
// cycle and compared one clock later. Sentinel expectations follow PATH_SENTINEL_EN.
module tb_path_sequencer;

   localparam int NODE_W    = 5;
   localparam int MAX_NODES = 14;
   localparam int IDX_W     = $clog2(MAX_NODES + 1);
   localparam int PW        = NODE_W * MAX_NODES;
   localparam int SW        = 3 * NODE_W + IDX_W + 5;

   logic              node_clk = 1'b0;
   logic              reset = 1'b1;
   logic [PW-1:0]     path_in = '0;
   logic [IDX_W-1:0]  path_len = '0;
   logic              path_valid = 1'b0;
   logic              path_ready;
   logic              node_adv = 1'b0;
   logic              abort = 1'b0;
   logic [NODE_W-1:0] prev_node, curr_node, next_node;
   logic [IDX_W-1:0]  node_idx;
   logic              busy, path_done, new_path, len_err;
   logic [1:0]        fsm_state;

   logic [SW-1:0]     exp_q[$];
   string             tag_q[$];
   int                n_vec = 0;
   int                n_err = 0;

   path_sequencer #(.NODE_W(NODE_W), .MAX_NODES(MAX_NODES), .END_NODE(6)) dut (
      .node_clk(node_clk), .reset(reset), .path_in(path_in), .path_len(path_len),
      .path_valid(path_valid), .path_ready(path_ready), .node_adv(node_adv), .abort(abort),
      .prev_node(prev_node), .curr_node(curr_node), .next_node(next_node),
      .node_idx(node_idx), .busy(busy), .path_done(path_done), .new_path(new_path),
      .len_err(len_err), .fsm_state(fsm_state)
   );

   always #5 node_clk = ~node_clk;

   function automatic logic [SW-1:0] mk(input int p, input int c, input int n, input int i,
                                        input int b, input int d, input int np,
                                        input int le, input int r);
      return {NODE_W'(p), NODE_W'(c), NODE_W'(n), IDX_W'(i),
              1'(b), 1'(d), 1'(np), 1'(le), 1'(r)};
   endfunction

   function automatic logic [PW-1:0] mkpath(input int n0, input int n1, input int n2,
                                            input int n3, input int n4);
      logic [PW-1:0] p;
      p = '0;
      p[0*NODE_W +: NODE_W] = NODE_W'(n0);
      p[1*NODE_W +: NODE_W] = NODE_W'(n1);
      p[2*NODE_W +: NODE_W] = NODE_W'(n2);
      p[3*NODE_W +: NODE_W] = NODE_W'(n3);
      p[4*NODE_W +: NODE_W] = NODE_W'(n4);
      return p;
   endfunction

   task automatic check_val(input string tag, input logic [SW-1:0] obs, input logic [SW-1:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got p/c/n/i/b/d/np/le/r=%0d/%0d/%0d/%0d/%b%b%b%b%b want %0d/%0d/%0d/%0d/%b%b%b%b%b",
                  tag, obs[SW-1 -: NODE_W], obs[SW-1-NODE_W -: NODE_W], obs[SW-1-2*NODE_W -: NODE_W],
                  obs[4+IDX_W -: IDX_W], obs[4], obs[3], obs[2], obs[1], obs[0],
                  exp[SW-1 -: NODE_W], exp[SW-1-NODE_W -: NODE_W], exp[SW-1-2*NODE_W -: NODE_W],
                  exp[4+IDX_W -: IDX_W], exp[4], exp[3], exp[2], exp[1], exp[0]);
      end
   endtask

   // Inputs are set by the caller before this task; it pushes the expectation,
   // clocks once, compares the popped entry and returns inputs to idle.
   task automatic apply(input string tag, input logic [SW-1:0] e);
      logic [SW-1:0] x;
      string t;
      exp_q.push_back(e);
      tag_q.push_back(tag);
      @(posedge node_clk);
      #1;
      x = exp_q.pop_front();
      t = tag_q.pop_front();
      check_val(t, {prev_node, curr_node, next_node, node_idx,
                    busy, path_done, new_path, len_err, path_ready}, x);
      reset = 1'b0; path_valid = 1'b0; node_adv = 1'b0; abort = 1'b0;
   endtask

   task automatic load(input logic [PW-1:0] p, input int len);
      path_in = p; path_len = IDX_W'(len); path_valid = 1'b1;
   endtask

   initial begin
      logic [PW-1:0] long_p;
      int nx;
      #2;
      reset = 1'b1;                         apply("reset",        mk(0,0,0,0,0,0,0,0,1));
      apply("idle",                                               mk(0,0,0,0,0,0,0,0,1));
      abort = 1'b1; node_adv = 1'b1;        apply("abort_idle",   mk(0,0,0,0,0,0,0,0,1));
      load(mkpath(3,7,9,12,0), 1);          apply("len1_err",     mk(0,0,0,0,0,0,0,1,1));
      load(mkpath(3,7,9,12,0), 15);         apply("len15_err",    mk(0,0,0,0,0,0,0,1,1));
      load(mkpath(3,7,9,12,0), 0);          apply("len0_err",     mk(0,0,0,0,0,0,0,1,1));
      apply("err_clear",                                          mk(0,0,0,0,0,0,0,0,1));

      load(mkpath(3,7,9,12,0), 4);          apply("load4",        mk(3,3,7,0,1,0,0,0,0));
      node_adv = 1'b1;                      apply("adv1",         mk(3,7,9,1,1,0,0,0,0));
      node_adv = 1'b1;                      apply("adv2",         mk(7,9,12,2,1,0,0,0,0));
      node_adv = 1'b1;                      apply("adv3_done",    mk(9,12,12,3,0,1,1,0,1));
      node_adv = 1'b1;                      apply("adv_in_done",  mk(9,12,12,3,0,0,1,0,1));
      load(mkpath(1,1,0,0,0), 1);           apply("err_in_done",  mk(9,12,12,3,0,0,1,1,1));

      load(mkpath(5,10,15,20,25), 5);       apply("load5",        mk(5,5,10,0,1,0,0,0,0));
      node_adv = 1'b1;                      apply("adv5_1",       mk(5,10,15,1,1,0,0,0,0));
      abort = 1'b1; node_adv = 1'b1;        apply("abort_adv",    mk(5,10,15,1,0,0,0,0,1));
      load(mkpath(4,8,0,0,0), 2);           apply("load2",        mk(4,4,8,0,1,0,0,0,0));
      node_adv = 1'b1;                      apply("len2_done",    mk(4,8,8,1,0,1,1,0,1));

      load(mkpath(1,2,5,0,0), 3); node_adv = 1'b1;
                                            apply("load_beats_adv", mk(1,1,2,0,1,0,0,0,0));
      node_adv = 1'b1;                      apply("adv3_1",       mk(1,2,5,1,1,0,0,0,0));
      load(mkpath(4,8,0,0,0), 2);           apply("valid_in_run", mk(1,2,5,1,1,0,0,0,0));
      reset = 1'b1;                         apply("reset_run",    mk(0,0,0,0,0,0,0,0,1));

      long_p = '0;
      for (int k = 0; k < MAX_NODES; k++) long_p[k*NODE_W +: NODE_W] = NODE_W'(10 + k);
      load(long_p, MAX_NODES);              apply("load_max",     mk(10,10,11,0,1,0,0,0,0));
      for (int j = 1; j < MAX_NODES; j++) begin
         nx = (j < MAX_NODES - 1) ? 10 + j + 1 : 10 + MAX_NODES - 1;
         node_adv = 1'b1;
         if (j == MAX_NODES - 1) apply("max_done", mk(10+j-1, 10+j, nx, j, 0,1,1,0,1));
         else                    apply("max_adv",  mk(10+j-1, 10+j, nx, j, 1,0,0,0,0));
      end

      load(mkpath(2,6,11,0,0), 3);          apply("load_sent",    mk(2,2,6,0,1,0,0,0,0));
      node_adv = 1'b1;
`ifdef PATH_SENTINEL_EN
      apply("sent_adv",                                           mk(2,6,11,1,0,1,1,0,1));
      abort = 1'b1;                         apply("sent_abort",   mk(2,6,11,1,0,0,1,0,1));
      load(mkpath(6,9,0,0,0), 2);           apply("sent_load0",   mk(6,6,9,0,0,1,1,0,1));
      abort = 1'b1;                         apply("sent_hold",    mk(6,6,9,0,0,0,1,0,1));
`else
      apply("sent_adv",                                           mk(2,6,11,1,1,0,0,0,0));
      abort = 1'b1;                         apply("sent_abort",   mk(2,6,11,1,0,0,0,0,1));
      load(mkpath(6,9,0,0,0), 2);           apply("sent_load0",   mk(6,6,9,0,1,0,0,0,0));
      abort = 1'b1;                         apply("sent_hold",    mk(6,6,9,0,0,0,0,0,1));
`endif

      if (exp_q.size() != 0) begin
         n_vec++;
         n_err++;
         $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
